// File: rtl/vga_pkg.sv
// Shared screen geometry, frame-memory widths and pixel-sink state encoding.
package vga_pkg;

    localparam int SCREEN_WIDTH  = 160;
    localparam int SCREEN_HEIGHT = 120;
    localparam int FRAME_PIXELS  = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int ADDR_W        = 15;
    localparam int COLOUR_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_FILL  = 2'd2
    } sink_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding {address, colour} pixel writes.
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible through the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pixel_sink.sv
// Clips and queues plotted pixels, writes them to frame memory, and can
// flush the queue then fill the whole frame with a background colour.
module pixel_sink
    import vga_pkg::*;
#(
    parameter int          WIDTH     = SCREEN_WIDTH,
    parameter int          HEIGHT    = SCREEN_HEIGHT,
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  BG_COLOUR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [7:0]  colour,
    output logic        ready,
    input  logic        clear,
    output logic        busy,
    output logic        clear_done,
    output logic [15:0] clip_count,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_wren,
    input  logic        mem_busy
);

    localparam int                DW         = ADDR_W + COLOUR_W;
    localparam logic [7:0]        X_LIM      = 8'(WIDTH);
    localparam logic [6:0]        Y_LIM      = 7'(HEIGHT);
    localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    sink_state_e       state_q, state_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              clear_done_q, clear_done_d;
    logic [15:0]       clip_q, clip_d;

    logic              accept, in_range, push, pop;
    logic              fifo_full, fifo_empty;
    logic [ADDR_W-1:0] pix_addr;
    logic [DW-1:0]     fifo_rdata;

    assign ready    = !fifo_full && (state_q == ST_IDLE);
    assign accept   = plot && ready;
    assign in_range = (x < X_LIM) && (y < Y_LIM);
    assign push     = accept && in_range;
    assign pix_addr = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);

    pixel_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({pix_addr, colour}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_wren_d   = 1'b0;
        clear_done_d = 1'b0;
        clip_d       = clip_q;
        pop          = 1'b0;

        if (accept && !in_range && clip_q != 16'hFFFF) begin
            clip_d = clip_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (clear) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (fifo_empty) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (!mem_busy) begin
                    mem_addr_d = fill_q;
                    mem_data_d = BG_COLOUR;
                    mem_wren_d = 1'b1;
                    if (fill_q == FRAME_LAST) begin
                        fill_d       = '0;
                        state_d      = ST_IDLE;
                        clear_done_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Queued pixels drain in IDLE and FLUSH; FILL only starts once empty.
        if (state_q != ST_FILL && !fifo_empty && !mem_busy) begin
            pop        = 1'b1;
            mem_addr_d = fifo_rdata[DW-1:COLOUR_W];
            mem_data_d = fifo_rdata[COLOUR_W-1:0];
            mem_wren_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fill_q       <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
            clear_done_q <= 1'b0;
            clip_q       <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_wren_q   <= mem_wren_d;
            clear_done_q <= clear_done_d;
            clip_q       <= clip_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign clear_done = clear_done_q;
    assign clip_count = clip_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wren   = mem_wren_q;

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 SHALL have parameters: WIDTH 160, visible columns; HEIGHT 120, visible rows; DEPTH 8, pixel FIFO entries; BG_COLOUR 8'h00, clear fill value.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-003 SHALL have drawing-side ports: plot  in  1  pixel valid; x  in  8  column; y  in  7  row; colour  in  8  pixel colour; ready  out  1  pixel accepted when plot&&ready.
REQ-004 SHALL have control ports: clear  in  1  request full-frame fill; busy  out  1  not IDLE; clear_done  out  1  one-cycle pulse at end of fill; clip_count  out  16  discarded out-of-range pixels.
REQ-005 SHALL have frame-memory ports: mem_addr  out  15  linear address; mem_data  out  8  write colour; mem_wren  out  1  write strobe; mem_busy  in  1  memory stall.

Function
REQ-006 SHALL treat a pixel as accepted on any rising edge with plot&&ready.
REQ-007 SHALL drive ready combinationally as !fifo_full && state==IDLE; it is not gated by plot, and a pop in the same cycle does not free a slot for that cycle.
REQ-008 SHALL discard an accepted pixel with x>=WIDTH or y>=HEIGHT without pushing it, and SHALL increment clip_count, saturating at 16'hFFFF.
REQ-009 SHALL push each in-range accepted pixel as {addr, colour}, with addr = y*WIDTH + x computed at acceptance (y*160 = (y<<7)+(y<<5)) and 15 bits wide, no truncation.
REQ-010 SHALL keep the FIFO first-in first-out, DEPTH entries, with wrap-around read and write pointers and an occupancy count of clog2(DEPTH)+1 bits.
REQ-011 SHALL register mem_addr, mem_data and mem_wren; on each edge with !mem_busy and a source available, SHALL load the next write and set mem_wren=1, else set mem_wren=0 and hold mem_addr and mem_data.
REQ-012 SHALL give a pixel accepted into an empty FIFO at edge N (mem_busy low) mem_wren=1 after edge N+1.
REQ-013 SHALL have states IDLE, FLUSH and FILL.
REQ-014 SHALL take the IDLE->FLUSH transition on clear; SHALL ignore clear outside IDLE, and the pixel (if any) accepted on that same edge is still queued.
REQ-015 SHALL keep ready=0 in FLUSH while the FIFO drains, and SHALL go FLUSH->FILL once the FIFO is empty and the last pop has issued.
REQ-016 SHALL in FILL write BG_COLOUR to addresses 0..WIDTH*HEIGHT-1 in order, one per non-stalled cycle, with a 15-bit fill counter that advances only when a write issues.
REQ-017 SHALL after the write to address 19199 go FILL->IDLE and pulse clear_done for exactly one cycle.
REQ-018 SHALL assert busy whenever state != IDLE.
REQ-019 SHALL freeze the FIFO pop and fill counter while mem_busy is high; no write is lost or duplicated.

Reset
REQ-020 SHALL on reset assertion, asynchronously, empty the FIFO and set: state IDLE; mem_wren 0; mem_addr 0; mem_data 0; clip_count 0; clear_done 0; fill counter 0.
REQ-021 SHALL abort a reset mid-FLUSH or mid-FILL with no further writes, and SHALL not pulse clear_done.
REQ-022 SHALL have busy=0 and ready=1 from the first cycle after reset deassertion.

Structure
REQ-023 SHALL place in a shared package (vga_pkg): screen WIDTH/HEIGHT constants, FRAME_PIXELS (19200), address width (15), colour width (8), and the state encoding.
REQ-024 SHALL implement the FIFO as one sub-module, pixel_fifo (parameterised depth and data width, push/pop/full/empty); address calculation, clipping and the FSM stay in pixel_sink.

Verification
REQ-025 SHALL cover: plot x=5, y=2, colour=8'hE0 into empty FIFO -> next cycle mem_wren=1, mem_addr=325, mem_data=8'hE0.
REQ-026 SHALL cover: plot x=159, y=119 -> mem_addr=19199; plot x=160, y=0 then x=0, y=120 -> no mem_wren, clip_count=2.
REQ-027 SHALL cover: mem_busy held high, plot 10 distinct pixels -> ready low after 8 accepted; release mem_busy -> 8 writes on consecutive cycles in acceptance order.
REQ-028 SHALL cover: 3 pixels queued with mem_busy high, then clear pulse, then release -> busy=1, 3 pixel writes, then 19200 writes of addr 0..19199 with data 8'h00, clear_done single pulse, busy=0.
REQ-029 SHALL cover: mem_busy toggled every other cycle during FILL -> every address written exactly once, in order.
REQ-030 SHALL cover: reset asserted at fill address 1000 -> mem_wren=0 immediately, state IDLE, no clear_done, ready=1 after release.
